fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, the queue entry count; legal values are powers of two, 2..16.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port fetch_en  in  1  high permits new memory requests.
REQ-006 SHALL have ports redirect_valid  in  1  and redirect_pc  in  32, a control-flow redirect (branch/JAL/JALR).
REQ-007 SHALL have ports mem_req  out  1  and mem_addr  out  32, a byte-address instruction read request.
REQ-008 SHALL have port mem_rdata  in  32  read data, valid exactly one cycle after mem_req; memory always accepts.
REQ-009 SHALL have ports out_valid  out  1, out_ready  in  1, out_inst  out  32 and out_pc  out  32, the decode-side handshake.

Function
REQ-010 SHALL hold fetch_pc, a credit count (occupancy plus in-flight) and the state {BOOT, RUN, HALT}.
REQ-011 SHALL assert mem_req when state is RUN, fetch_en=1, redirect_valid=0 and credits < DEPTH.
REQ-012 SHALL drive mem_addr = fetch_pc; fetch_pc increments by 4 per issued request, wrapping 32'hFFFF_FFFC -> 0.
REQ-013 SHALL push {fetch_pc of request, mem_rdata} into the queue in the cycle after the request, unless that request was killed.
REQ-014 SHALL present the head entry on out_inst/out_pc with out_valid=1 whenever the queue is non-empty and redirect_valid=0.
REQ-015 SHALL pop exactly when out_valid and out_ready are both 1.
REQ-016 SHALL allow a push and a pop in the same cycle at any occupancy, including full; the credit scheme makes overflow impossible.
REQ-017 SHALL, on redirect_valid, flush the queue, kill any in-flight response and load fetch_pc <= {redirect_pc[31:2], 2'b00}.
REQ-018 SHALL give redirect priority over a same-cycle pop, push or request; the issue-cycle request is suppressed.
REQ-019 SHALL issue the first request from a redirect target in cycle t+1 and assert out_valid for it in cycle t+2.
REQ-020 SHALL transition BOOT -> RUN one cycle after reset release, RUN -> HALT when fetch_en=0, and HALT -> RUN when fetch_en=1.
REQ-021 SHALL, in HALT, keep delivering queued and in-flight entries but issue no requests.
REQ-022 SHALL, on back-to-back redirects, use only the last target.

Reset
REQ-023 SHALL, while rst=0, set fetch_pc=RESET_PC, state=BOOT, queue empty, credits=0, kill flag clear.
REQ-024 SHALL drive all outputs to 0 in reset, except mem_addr=RESET_PC.
REQ-025 SHALL, when reset is asserted mid-operation, discard all queued and in-flight state immediately (asynchronously).
REQ-026 SHALL issue the first request with mem_addr=RESET_PC in the first RUN cycle.

Configuration
REQ-027 SHALL, with FETCH_PERF_CNT_EN defined, add outputs perf_fetched (32) and perf_flushed (32).
REQ-028 SHALL, under FETCH_PERF_CNT_EN, increment perf_fetched per pop and add the discarded entry count plus killed in-flight responses to perf_flushed per redirect.
REQ-029 SHALL make both counters wrap and reset to 0.
REQ-030 SHALL, without FETCH_PERF_CNT_EN, omit both ports and counters entirely, with all other behaviour identical.

Structure
REQ-031 SHALL place the state encoding, the queue-entry type {pc, inst} and NOP constant 32'h0000_0013 in shared package fetch_pkg.
REQ-032 SHALL implement storage as sub-module fetch_fifo (parameter DEPTH, entry width 64, push/pop/flush, full/empty, count).
REQ-033 SHALL keep PC generation, credits, kill logic and FSM in fetch_queue.

Verification
REQ-034 SHALL check that after reset release with out_ready=1, out_pc reads 0,4,8,12 on consecutive cycles starting at cycle 2.
REQ-035 SHALL check that, with out_ready=0 and DEPTH=4, exactly 4 requests issue, mem_req then stays 0, and 4 entries drain in order once out_ready=1.
REQ-036 SHALL check that redirect_pc=32'h1000_0042 mid-stream gives no stale entry out and a next out_pc of 32'h1000_0040 two cycles later.
REQ-037 SHALL check that redirect, a push and a pop all in the same cycle give an empty queue, no pop counted and fetch_pc set to the target.
REQ-038 SHALL check that fetch_pc=32'hFFFF_FFF8 yields out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 SHALL check that, under FETCH_PERF_CNT_EN, a redirect with 3 queued entries and 1 in flight raises perf_flushed by 4.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } fetch_state_e;

  // One queued fetch result: the request address and the returned instruction.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // addi x0, x0, 0
  localparam logic [31:0] NopInst = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Circular-buffer storage for fetch entries with synchronous flush.
// Push and pop may coincide at any occupancy; the caller guarantees no overflow.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  fetch_entry_t i_push_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic         o_full,
  output logic         o_empty,
  output logic [CW-1:0] o_count
);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  fetch_entry_t  r_mem [DEPTH];

  // Pointer and occupancy bookkeeping; flush drops everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  // Entry storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: PC generation, credit-limited memory requests,
// redirect/kill handling and a decoupling queue toward decode.
// Optional feature: define FETCH_PERF_CNT_EN to add perf_fetched/perf_flushed counters.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed,
`endif
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);

  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  fetch_state_e  r_state;
  fetch_state_e  w_state_d;
  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_credits;
  // A response arrives this cycle for a request issued last cycle; a redirect
  // in this cycle kills it by blocking the push.
  logic          r_inflight;
  logic [31:0]   r_inflight_pc;

  logic          w_mem_req;
  logic          w_push;
  logic          w_pop;
  logic          w_out_valid;
  logic          w_fifo_push;
  logic          w_fifo_pop;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_count;
  fetch_entry_t  w_fifo_head;
  fetch_entry_t  w_resp;
  fetch_entry_t  w_head;
  logic [31:0]   w_redirect_target;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= StBoot;
    else      r_state <= w_state_d;
  end

  // FSM next state: leave BOOT unconditionally, then follow fetch_en.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StBoot:  w_state_d = StRun;
      StRun:   if (!fetch_en) w_state_d = StHalt;
      StHalt:  if (fetch_en) w_state_d = StRun;
      default: w_state_d = StBoot;
    endcase
  end

  assign w_redirect_target = redirect_pc & ~32'h3;
  assign w_mem_req = (r_state == StRun) && fetch_en && !redirect_valid && (r_credits < DepthC);

  assign w_resp = '{pc: r_inflight_pc, inst: mem_rdata};
  assign w_push = r_inflight && !redirect_valid;

  // An empty queue forwards the arriving response straight to decode.
  assign w_head      = w_fifo_empty ? w_resp : w_fifo_head;
  assign w_out_valid = !redirect_valid && (!w_fifo_empty || r_inflight);
  assign w_pop       = w_out_valid && out_ready;
  assign w_fifo_push = w_push && !(w_fifo_empty && w_pop);
  assign w_fifo_pop  = w_pop && !w_fifo_empty;

  // PC, credits and in-flight tracking; redirect overrides everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_credits     <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_mem_req;
      if (w_mem_req) r_inflight_pc <= r_fetch_pc;
      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_target;
        r_credits  <= '0;
      end else begin
        if (w_mem_req) r_fetch_pc <= r_fetch_pc + 32'd4;
        r_credits <= r_credits + CW'(w_mem_req) - CW'(w_pop);
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_fifo_push),
    .i_push_data(w_resp),
    .i_pop      (w_fifo_pop),
    .i_flush    (redirect_valid),
    .o_head     (w_fifo_head),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty),
    .o_count    (w_fifo_count)
  );

  // Credits bound occupancy, so the queue can never be pushed while full without a pop.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(w_fifo_full && w_fifo_push && !w_fifo_pop));
  a_credits_cover: assert property (@(posedge clk) disable iff (!rst)
    r_credits >= w_fifo_count);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_flushed;

  // Delivered-instruction and discarded-work counters, both free-running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetched <= '0;
      r_perf_flushed <= '0;
    end else begin
      if (w_pop) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (redirect_valid) begin
        r_perf_flushed <= r_perf_flushed + 32'(w_fifo_count) + 32'(r_inflight);
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_flushed = r_perf_flushed;
`endif

  assign mem_req   = w_mem_req;
  assign mem_addr  = r_fetch_pc;
  assign out_valid = w_out_valid;
  assign out_inst  = w_out_valid ? w_head.inst : 32'h0;
  assign out_pc    = w_out_valid ? w_head.pc : 32'h0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, RESET_PC=0).
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = 32'h0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fetch_queue #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (4)
  ) dut (
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched  (perf_fetched),
    .perf_flushed  (perf_flushed),
`endif
    .clk           (clk),
    .rst           (rst),
    .fetch_en      (fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // Memory: data for the address requested in the previous cycle.
  always @(posedge clk) begin
    mem_rdata <= mem_req ? inst_of(mem_addr) : 32'h0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc);
    check_eq({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
    check_eq({tag, "_pc"}, out_pc, pc);
    check_eq({tag, "_inst"}, out_inst, inst_of(pc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_req;
    rst = 1'b0;
    fetch_en = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    smp();
    check_eq("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check_eq("rst_out_pc", out_pc, 32'h0);
    check_eq("rst_out_inst", out_inst, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check_eq("rst_perf_fetched", perf_fetched, 32'h0);
    check_eq("rst_perf_flushed", perf_flushed, 32'h0);
`endif

    // Boot and in-order stream from RESET_PC.
    cyc(); rst = 1'b1;
    smp(); check_eq("boot_noreq", {31'h0, mem_req}, 32'h0);
    cyc(); smp();
    check_eq("first_req", {31'h0, mem_req}, 32'h1);
    check_eq("first_addr", mem_addr, 32'h0);
    check_eq("first_noout", {31'h0, out_valid}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(); smp(); expect_out("seq", 32'(i * 4));
    end

    // Backpressure: credits cap requests at DEPTH, then drain in order.
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h100; out_ready = 1'b0;
    smp(); check_eq("bp_redir_noout", {31'h0, out_valid}, 32'h0);
    n_req = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(); redirect_valid = 1'b0;
      smp();
      if (mem_req) begin
        check_eq("bp_addr", mem_addr, 32'h100 + 32'(n_req * 4));
        n_req++;
      end
    end
    check_eq("bp_req_count", 32'(n_req), 32'd4);
    check_eq("bp_stalled", {31'h0, mem_req}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(); out_ready = 1'b1;
      smp(); expect_out("drain", 32'h100 + 32'(i * 4));
    end

    // Mid-stream redirect to an unaligned target.
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h1000_0042;
    smp(); check_eq("redir_nostale", {31'h0, out_valid}, 32'h0);
    check_eq("redir_noreq", {31'h0, mem_req}, 32'h0);
    cyc(); redirect_valid = 1'b0;
    smp();
    check_eq("redir_t1_noout", {31'h0, out_valid}, 32'h0);
    check_eq("redir_t1_req", {31'h0, mem_req}, 32'h1);
    check_eq("redir_t1_addr", mem_addr, 32'h1000_0040);
    cyc(); smp(); expect_out("redir_t2", 32'h1000_0040);
    cyc(); smp(); expect_out("redir_t3", 32'h1000_0044);

    // Address wrap at the top of the space.
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cyc(); redirect_valid = 1'b0;
    cyc(); smp(); expect_out("wrap0", 32'hFFFF_FFF8);
    cyc(); smp(); expect_out("wrap1", 32'hFFFF_FFFC);
    cyc(); smp(); expect_out("wrap2", 32'h0000_0000);

    // HALT: in-flight work still delivered, no requests; resume one cycle late.
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h400;
    cyc(); redirect_valid = 1'b0;
    smp(); check_eq("halt_pre_addr", mem_addr, 32'h400);
    cyc(); smp(); expect_out("halt_pre_out", 32'h400);
    cyc(); fetch_en = 1'b0;
    smp(); check_eq("halt_noreq0", {31'h0, mem_req}, 32'h0);
    expect_out("halt_drain", 32'h404);
    cyc(); smp();
    check_eq("halt_noreq1", {31'h0, mem_req}, 32'h0);
    check_eq("halt_empty", {31'h0, out_valid}, 32'h0);
    cyc(); fetch_en = 1'b1;
    smp(); check_eq("halt_exit_noreq", {31'h0, mem_req}, 32'h0);
    cyc(); smp();
    check_eq("resume_req", {31'h0, mem_req}, 32'h1);
    check_eq("resume_addr", mem_addr, 32'h408);
    cyc(); smp(); expect_out("resume_out", 32'h408);

    // Back-to-back redirects: only the last target survives.
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h500;
    cyc(); redirect_pc = 32'h600;
    smp(); check_eq("b2b_noreq", {31'h0, mem_req}, 32'h0);
    cyc(); redirect_valid = 1'b0;
    smp(); check_eq("b2b_addr", mem_addr, 32'h600);
    cyc(); smp(); expect_out("b2b_out", 32'h600);

    // Asynchronous reset mid-operation with a backed-up queue.
    cyc(); out_ready = 1'b0;
    cyc(); smp();
    #2 rst = 1'b0;
    #1;
    check_eq("arst_out_valid", {31'h0, out_valid}, 32'h0);
    check_eq("arst_mem_req", {31'h0, mem_req}, 32'h0);
    check_eq("arst_mem_addr", mem_addr, 32'h0);
    check_eq("arst_out_pc", out_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check_eq("arst_perf_fetched", perf_fetched, 32'h0);
`endif
    cyc();
    cyc(); rst = 1'b1;
    smp(); check_eq("reboot_noreq", {31'h0, mem_req}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(); smp(); check_eq("refill_addr", mem_addr, 32'(i * 4));
      check_eq("refill_req", {31'h0, mem_req}, 32'h1);
    end
    // 3 queued + 1 in flight at this redirect.
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h200;
    smp(); check_eq("flush4_noreq", {31'h0, mem_req}, 32'h0);
    check_eq("flush4_noout", {31'h0, out_valid}, 32'h0);
    cyc(); redirect_valid = 1'b0;
    smp(); check_eq("flush4_addr", mem_addr, 32'h200);
`ifdef FETCH_PERF_CNT_EN
    check_eq("perf_flushed_4", perf_flushed, 32'd4);
`endif
    cyc(); smp(); expect_out("stall_head", 32'h200);
    // Redirect with a pending push and an attempted pop in the same cycle.
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h300; out_ready = 1'b1;
    smp(); check_eq("rpp_noout", {31'h0, out_valid}, 32'h0);
    check_eq("rpp_noreq", {31'h0, mem_req}, 32'h0);
    cyc(); redirect_valid = 1'b0;
    smp(); check_eq("rpp_empty", {31'h0, out_valid}, 32'h0);
    check_eq("rpp_addr", mem_addr, 32'h300);
`ifdef FETCH_PERF_CNT_EN
    check_eq("rpp_no_pop", perf_fetched, 32'd0);
    check_eq("rpp_flushed", perf_flushed, 32'd6);
`endif
    cyc(); smp(); expect_out("rpp_out0", 32'h300);
    cyc(); smp(); expect_out("rpp_out1", 32'h304);
`ifdef FETCH_PERF_CNT_EN
    check_eq("perf_fetched_1", perf_fetched, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
